wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back stage plus architectural register file; consumes the MEM/WB pipeline register outputs.
//  - Selects the write-back value and destination, then commits to a 32-entry register file.
//  - Serves two combinational read ports to ID, with write-through bypass.
//  - Keeps registered commit-trace outputs and a commit counter for debug and verification.
// PARAMETERS
//  DATA_W   32  register and data width
//  ADDR_W   5   register index width
//  NREG     32  number of registers; index 0 is hardwired zero
//  RA_REG   31  destination forced when Ra=1 (link register)
// PORTS
//  Clk        in   1       clock; all state updates on posedge
//  Rst        in   1       synchronous, active-high reset
//  RegWrite   in   1       write-back enable (from MEM/WB)
//  MemToReg   in   1       1: write MemData, 0: write ALUResult
//  Ra         in   1       link write: dest=RA_REG, data=ALUResult (carries link address)
//  MemData    in   DATA_W  load data (from MEM/WB)
//  ALUResult  in   DATA_W  ALU result or link address (from MEM/WB)
//  WriteReg   in   ADDR_W  destination index (from MEM/WB)
//  ReadReg1   in   ADDR_W  read port 1 index (ID stage)
//  ReadReg2   in   ADDR_W  read port 2 index (ID stage)
//  ReadData1  out  DATA_W  read port 1 data, combinational
//  ReadData2  out  DATA_W  read port 2 data, combinational
//  WBData     out  DATA_W  selected write-back value, combinational (for EX forwarding)
//  WBReg      out  ADDR_W  effective destination, combinational
//  CommitVld  out  1       registered; 1 for one cycle after a committed write
//  CommitReg  out  ADDR_W  registered; index of last committed write
//  CommitData out  DATA_W  registered; value of last committed write
//  CommitCnt  out  32      registered; number of committed writes since reset
// BEHAVIOUR
//  Selection (combinational):
//  - WBReg = Ra ? RA_REG : WriteReg.
//  - WBData = Ra ? ALUResult : (MemToReg ? MemData : ALUResult). Ra overrides MemToReg.
//  Commit:
//  - commit = RegWrite & (WBReg != 0) & ~Rst.
//  - On posedge with commit: regs[WBReg] <= WBData.
//  - Writes to index 0 are discarded and are not commits.
//  - Latency: a write is architecturally visible 1 cycle later and via bypass in the same cycle.
//  Reads:
//  - ReadDataN = 0 if ReadRegN==0.
//  - Otherwise ReadDataN = WBData if commit is pending this cycle and ReadRegN==WBReg.
//  - Otherwise ReadDataN = regs[ReadRegN].
//  - Both ports may read the same index simultaneously; both see the same value.
//  Trace:
//  - On posedge: CommitVld <= commit.
//  - If commit: CommitReg <= WBReg, CommitData <= WBData, CommitCnt <= CommitCnt+1.
//  - Otherwise CommitReg, CommitData and CommitCnt hold.
//  - CommitCnt wraps 0xFFFFFFFF -> 0.
//  Reset:
//  - Rst=1 at posedge clears all regs, CommitVld, CommitReg, CommitData and CommitCnt to 0.
//  - Reset wins over a simultaneous write; that write is lost, not counted, and not bypassed.
//  - Combinational outputs follow their inputs during reset.
//  - ReadDataN reads stored values during reset; there is no bypass while Rst=1.
//  Unknowns: no X may propagate from regs after reset, since every entry is cleared.
// TESTING
//  T1 Reset:
//     Rst=1 for 2 cycles, then read all 32 indices.
//     -> all ReadData=0, CommitCnt=0, CommitVld=0.
//  T2 ALU write then read:
//     RegWrite=1, MemToReg=0, WriteReg=8, ALUResult=0x1234 for 1 cycle.
//     -> next cycle ReadReg1=8 gives 0x1234; CommitVld=1, CommitReg=8, CommitCnt=1.
//  T3 Load and bypass:
//     RegWrite=1, MemToReg=1, WriteReg=9, MemData=0xDEADBEEF, ReadReg2=9 in the same cycle.
//     -> ReadData2=0xDEADBEEF combinationally.
//  T4 Link write:
//     RegWrite=1, Ra=1, MemToReg=1, WriteReg=4, ALUResult=0x0040_0010, MemData=0x55.
//     -> WBReg=31, regs[31]=0x00400010, regs[4] unchanged.
//  T5 Zero register:
//     RegWrite=1, WriteReg=0, ALUResult=0xFFFF, ReadReg1=0.
//     -> ReadData1=0 same and next cycle; CommitVld=0, CommitCnt unchanged.
//  T6 Reset during write:
//     Rst=1 with RegWrite=1, WriteReg=5, ALUResult=7 after prior writes.
//     -> regs[5]=0, CommitCnt=0, CommitVld=0 next cycle.

Source files
------------

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, 32-entry register file with bypass, commit trace
// Register 0 is hardwired zero; reset clears every entry so no X leaves the file.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int RA_REG = 31
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RegWrite,
  input  logic              MemToReg,
  input  logic              Ra,
  input  logic [DATA_W-1:0] MemData,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WBData,
  output logic [ADDR_W-1:0] WBReg,
  output logic              CommitVld,
  output logic [ADDR_W-1:0] CommitReg,
  output logic [DATA_W-1:0] CommitData,
  output logic [31:0]       CommitCnt
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_commit_vld;
  logic [ADDR_W-1:0] r_commit_reg;
  logic [DATA_W-1:0] r_commit_data;
  logic [31:0]       r_commit_cnt;

  logic [ADDR_W-1:0] w_wb_reg;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_commit;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // A link write forces the link register and always carries ALUResult.
  assign w_wb_reg  = Ra ? ADDR_W'(RA_REG) : WriteReg;
  assign w_wb_data = (Ra || !MemToReg) ? ALUResult : MemData;
  assign w_commit  = RegWrite && (w_wb_reg != '0) && !Rst;

  always_comb begin
    w_rd1 = r_regs[ReadReg1];
    if (ReadReg1 == '0)
      w_rd1 = '0;
    else if (w_commit && (ReadReg1 == w_wb_reg))
      w_rd1 = w_wb_data;
  end

  always_comb begin
    w_rd2 = r_regs[ReadReg2];
    if (ReadReg2 == '0)
      w_rd2 = '0;
    else if (w_commit && (ReadReg2 == w_wb_reg))
      w_rd2 = w_wb_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[w_wb_reg] <= w_wb_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_commit_vld  <= 1'b0;
      r_commit_reg  <= '0;
      r_commit_data <= '0;
      r_commit_cnt  <= '0;
    end else begin
      r_commit_vld <= w_commit;
      if (w_commit) begin
        r_commit_reg  <= w_wb_reg;
        r_commit_data <= w_wb_data;
        r_commit_cnt  <= r_commit_cnt + 32'd1;
      end
    end
  end

  assign ReadData1  = w_rd1;
  assign ReadData2  = w_rd2;
  assign WBData     = w_wb_data;
  assign WBReg      = w_wb_reg;
  assign CommitVld  = r_commit_vld;
  assign CommitReg  = r_commit_reg;
  assign CommitData = r_commit_data;
  assign CommitCnt  = r_commit_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile against an array reference model
module tb_wb_regfile;

  logic        Clk = 1'b0;
  logic        Rst, RegWrite, MemToReg, Ra;
  logic [31:0] MemData, ALUResult;
  logic [4:0]  WriteReg, ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2, WBData;
  logic [4:0]  WBReg;
  logic        CommitVld;
  logic [4:0]  CommitReg;
  logic [31:0] CommitData;
  logic [31:0] CommitCnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [32];
  logic        m_vld;
  logic [4:0]  m_creg;
  logic [31:0] m_cdata;
  logic [31:0] m_cnt;

  always #5 Clk = ~Clk;

  wb_regfile dut (
    .Clk(Clk), .Rst(Rst), .RegWrite(RegWrite), .MemToReg(MemToReg), .Ra(Ra),
    .MemData(MemData), .ALUResult(ALUResult), .WriteReg(WriteReg),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .WBData(WBData), .WBReg(WBReg), .CommitVld(CommitVld),
    .CommitReg(CommitReg), .CommitData(CommitData), .CommitCnt(CommitCnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] m_dest();
    return Ra ? 5'd31 : WriteReg;
  endfunction

  function automatic logic [31:0] m_data();
    if (Ra) return ALUResult;
    return MemToReg ? MemData : ALUResult;
  endfunction

  function automatic bit m_pending();
    return RegWrite && (m_dest() != 5'd0) && !Rst;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (m_pending() && idx == m_dest()) return m_data();
    return m_regs[idx];
  endfunction

  task automatic drive(input bit rst, input bit rw, input bit m2r, input bit ra,
                       input logic [31:0] md, input logic [31:0] alu, input logic [4:0] wr,
                       input logic [4:0] rr1, input logic [4:0] rr2);
    Rst = rst; RegWrite = rw; MemToReg = m2r; Ra = ra;
    MemData = md; ALUResult = alu; WriteReg = wr; ReadReg1 = rr1; ReadReg2 = rr2;
  endtask

  // Check combinational outputs, clock once, advance the model, check the trace.
  task automatic cycle(input string tag);
    bit          pend;
    logic [4:0]  dst;
    logic [31:0] dat;
    #1;
    check({tag, ".wbreg"}, {27'd0, WBReg}, {27'd0, m_dest()});
    check({tag, ".wbdata"}, WBData, m_data());
    check({tag, ".rd1"}, ReadData1, m_read(ReadReg1));
    check({tag, ".rd2"}, ReadData2, m_read(ReadReg2));
    pend = m_pending();
    dst  = m_dest();
    dat  = m_data();
    @(posedge Clk);
    if (Rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_vld = 1'b0; m_creg = 5'd0; m_cdata = 32'd0; m_cnt = 32'd0;
    end else if (pend) begin
      m_regs[dst] = dat;
      m_vld = 1'b1; m_creg = dst; m_cdata = dat; m_cnt = m_cnt + 32'd1;
    end else begin
      m_vld = 1'b0;
    end
    #1;
    check({tag, ".cvld"}, {31'd0, CommitVld}, {31'd0, m_vld});
    check({tag, ".creg"}, {27'd0, CommitReg}, {27'd0, m_creg});
    check({tag, ".cdata"}, CommitData, m_cdata);
    check({tag, ".ccnt"}, CommitCnt, m_cnt);
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'hx;
    m_vld = 1'bx; m_creg = 5'hx; m_cdata = 32'hx; m_cnt = 32'hx;

    // T1 reset, then read every index on both ports
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_vld = 0; m_creg = 0; m_cdata = 0; m_cnt = 0;
    cycle("t1_rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      #1;
      check("t1_rd1", ReadData1, 32'd0);
      check("t1_rd2", ReadData2, 32'd0);
    end
    check("t1_cnt", CommitCnt, 32'd0);
    check("t1_vld", {31'd0, CommitVld}, 32'd0);

    // T2 ALU write then read
    drive(0, 1, 0, 0, 32'h0, 32'h1234, 5'd8, 5'd0, 5'd0);
    cycle("t2_wr");
    check("t2_vld", {31'd0, CommitVld}, 32'd1);
    check("t2_creg", {27'd0, CommitReg}, 32'd8);
    check("t2_cnt", CommitCnt, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd0);
    #1 check("t2_rd", ReadData1, 32'h1234);
    cycle("t2_rd");

    // T3 load with same-cycle bypass
    drive(0, 1, 1, 0, 32'hDEADBEEF, 32'h1, 5'd9, 5'd0, 5'd9);
    #1 check("t3_bypass", ReadData2, 32'hDEADBEEF);
    cycle("t3");

    // T4 link write overrides MemToReg and destination
    drive(0, 1, 1, 1, 32'h55, 32'h0040_0010, 5'd4, 5'd4, 5'd31);
    #1 check("t4_wbreg", {27'd0, WBReg}, 32'd31);
    cycle("t4");
    drive(0, 0, 0, 0, 0, 0, 0, 5'd31, 5'd4);
    #1 check("t4_r31", ReadData1, 32'h0040_0010);
    check("t4_r4", ReadData2, 32'd0);
    cycle("t4_rd");

    // T5 writes to register 0 are not commits
    drive(0, 1, 0, 0, 0, 32'hFFFF, 5'd0, 5'd0, 5'd0);
    #1 check("t5_rd_same", ReadData1, 32'd0);
    cycle("t5");
    check("t5_vld", {31'd0, CommitVld}, 32'd0);
    check("t5_cnt", CommitCnt, 32'd3);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    #1 check("t5_rd_next", ReadData1, 32'd0);

    // T6 reset wins over a simultaneous write and does not bypass
    drive(0, 1, 0, 0, 0, 32'hAA, 5'd5, 5'd0, 5'd0);
    cycle("t6_pre");
    drive(1, 1, 0, 0, 0, 32'd7, 5'd5, 5'd5, 5'd5);
    #1 check("t6_nobypass", ReadData1, 32'hAA);
    cycle("t6_rst");
    check("t6_cnt", CommitCnt, 32'd0);
    check("t6_vld", {31'd0, CommitVld}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd5);
    #1 check("t6_r5", ReadData1, 32'd0);

    // Randomized traffic with occasional resets and forced bypass reads
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr, r1, r2;
      bit ra;
      wr = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 7) == 0);
      r1 = ($urandom_range(0, 3) == 0) ? (ra ? 5'd31 : wr) : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? (ra ? 5'd31 : wr) : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom), ra, $urandom, $urandom, wr, r1, r2);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
